// File: rtl/pw_entry_ctrl.sv
// Password keypad sequencer. Turns debounced button levels into single press
// events, collects a four-digit code, compares it with a secret, enforces an
// inter-digit timeout and locks the keypad after repeated failures.
module pw_entry_ctrl #(
  parameter logic [7:0]  CODE        = 8'hE4,        // digit0 in [1:0]
  parameter int unsigned TIMEOUT_CYC = 50_000_000,   // idle cycles allowed between digits
  parameter int unsigned MAX_FAIL    = 3,            // failures before lockout (1..3)
  parameter int unsigned LOCK_CYC    = 250_000_000   // lockout duration
) (
  input  logic       clkin,
  input  logic       reset,      // asynchronous, active low
  input  logic       a_pb,
  input  logic       b_pb,
  input  logic       c_pb,
  input  logic       d_pb,
  output logic       unlock,
  output logic       fail,
  output logic       locked,
  output logic [1:0] fail_cnt,
  output logic [4:0] OUT
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned LCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCK_CYC - 1);
  localparam logic [1:0]       FAIL_MAX = 2'(MAX_FAIL);

  localparam logic [4:0] OUT_IDLE  = 5'd0;
  localparam logic [4:0] OUT_GRANT = 5'd12;
  localparam logic [4:0] OUT_DENY  = 5'b10001;
  localparam logic [4:0] OUT_LOCK  = 5'b11111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_GRANT,
    S_DENY,
    S_LOCK
  } state_t;

  // Button levels packed so that bit index equals digit value.
  logic [3:0] lvl;
  logic [3:0] prev_q;
  logic [3:0] rise;

  assign lvl  = {d_pb, c_pb, b_pb, a_pb};
  assign rise = lvl & ~prev_q;

  logic       press_d, press_q;
  logic       valid_d, valid_q;
  logic [1:0] digit_d, digit_q;

  // Classify this cycle's rising levels into a press event and its digit.
  // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    press_d = |rise;
    // A press is only meaningful when the rising button is the only one down.
    valid_d = $onehot(rise) && ((lvl & ~rise) == 4'b0000);
    digit_d = 2'd0;
    case (rise)
      4'b0001: digit_d = 2'd0;
      4'b0010: digit_d = 2'd1;
      4'b0100: digit_d = 2'd2;
      4'b1000: digit_d = 2'd3;
      default: digit_d = 2'd0;
    endcase
  end

  // Edge-detect history and the registered press event; these run in every
  // state so a button held across a busy period never fires afterwards.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      prev_q  <= 4'b0000;
      press_q <= 1'b0;
      valid_q <= 1'b0;
      digit_q <= 2'd0;
    end else begin
      prev_q  <= lvl;
      press_q <= press_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
    end
  end

  state_t           state_q;
  logic [1:0]       idx_q;
  logic             mism_q;
  logic [TMO_W-1:0] tmo_q;
  logic [LCK_W-1:0] lock_cnt_q;
  logic             unlock_q;
  logic             fail_q;
  logic             locked_q;
  logic [1:0]       fail_cnt_q;
  logic [4:0]       out_q;

  // An invalid press always counts as a wrong digit. In IDLE idx_q is zero,
  // so the same slice selects digit0.
  logic       digit_wrong;
  logic       mism_next;
  logic [1:0] fail_inc;

  assign digit_wrong = !valid_q || (digit_q != CODE[{idx_q, 1'b0} +: 2]);
  assign mism_next   = mism_q | digit_wrong;
  assign fail_inc    = (fail_cnt_q == FAIL_MAX) ? fail_cnt_q : fail_cnt_q + 2'd1;

  // Entry sequencer with registered status outputs.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      mism_q     <= 1'b0;
      tmo_q      <= '0;
      lock_cnt_q <= '0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
      fail_cnt_q <= 2'd0;
      out_q      <= OUT_IDLE;
    end else begin
      unlock_q <= 1'b0;
      fail_q   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          out_q <= OUT_IDLE;
          if (press_q) begin
            mism_q  <= digit_wrong;
            idx_q   <= 2'd1;
            tmo_q   <= '0;
            state_q <= S_ENTRY;
          end
        end

        S_ENTRY: begin
          out_q <= {3'b000, idx_q};
          // A press in the expiry cycle wins over the timeout.
          if (press_q) begin
            tmo_q <= '0;
            if (idx_q == 2'd3) begin
              idx_q   <= 2'd0;
              mism_q  <= 1'b0;
              state_q <= mism_next ? S_DENY : S_GRANT;
            end else begin
              idx_q  <= idx_q + 2'd1;
              mism_q <= mism_next;
            end
          end else if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            idx_q   <= 2'd0;
            mism_q  <= 1'b0;
            state_q <= S_DENY;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        S_GRANT: begin
          unlock_q   <= 1'b1;
          out_q      <= OUT_GRANT;
          fail_cnt_q <= 2'd0;
          state_q    <= S_IDLE;
        end

        S_DENY: begin
          fail_q     <= 1'b1;
          out_q      <= OUT_DENY;
          fail_cnt_q <= fail_inc;
          if (fail_inc == FAIL_MAX) begin
            // Raise locked together with the fail pulse so it covers the
            // whole lockout window.
            locked_q   <= 1'b1;
            lock_cnt_q <= '0;
            state_q    <= S_LOCK;
          end else begin
            state_q <= S_IDLE;
          end
        end

        S_LOCK: begin
          if (lock_cnt_q == LCK_LAST) begin
            lock_cnt_q <= '0;
            fail_cnt_q <= 2'd0;
            locked_q   <= 1'b0;
            out_q      <= OUT_IDLE;
            state_q    <= S_IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + LCK_W'(1);
            locked_q   <= 1'b1;
            out_q      <= OUT_LOCK;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign unlock   = unlock_q;
  assign fail     = fail_q;
  assign locked   = locked_q;
  assign fail_cnt = fail_cnt_q;
  assign OUT      = out_q;

endmodule

// File: tb/tb_pw_entry_ctrl.sv
// Bench for pw_entry_ctrl: a cycle-level model of the keypad rules predicts
// unlock / fail / lockout-end events, which a monitor compares as the DUT emits them.
module tb_pw_entry_ctrl;

  localparam logic [7:0] CODE = 8'hE4;
  localparam int T    = 20;
  localparam int MAXF = 3;
  localparam int N    = 50;

  localparam int EV_UNLOCK = 0;
  localparam int EV_FAIL   = 1;
  localparam int EV_LOCKEND = 2;

  logic       clkin = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] lv    = 4'b0000;
  logic       unlock, fail, locked;
  logic [1:0] fail_cnt;
  logic [4:0] OUT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int kind;
    int cyc;
    int fcnt;
    int out;
    int lck;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state.
  logic [3:0] m_prev;
  int         m_code[$];
  int         m_last;
  int         m_accept;
  int         m_fails;

  pw_entry_ctrl #(
    .CODE       (CODE),
    .TIMEOUT_CYC(T),
    .MAX_FAIL   (MAXF),
    .LOCK_CYC   (N)
  ) dut (
    .clkin   (clkin),
    .reset   (reset),
    .a_pb    (lv[0]),
    .b_pb    (lv[1]),
    .c_pb    (lv[2]),
    .d_pb    (lv[3]),
    .unlock  (unlock),
    .fail    (fail),
    .locked  (locked),
    .fail_cnt(fail_cnt),
    .OUT     (OUT)
  );

  always #5 clkin = ~clkin;

  always @(posedge clkin) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int c, input int fcnt, input int out, input int lck);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.fcnt = fcnt;
    e.out  = out;
    e.lck  = lck;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_prev   = 4'b0000;
    m_code.delete();
    m_last   = 0;
    m_accept = 0;
    m_fails  = 0;
    exp_q.delete();
  endtask

  // Failed attempt whose fail pulse appears on edge f.
  task automatic model_fail(input int f);
    m_fails = (m_fails < MAXF) ? m_fails + 1 : MAXF;
    if (m_fails == MAXF) begin
      push_exp(EV_FAIL, f, m_fails, 17, 1);
      push_exp(EV_LOCKEND, f + N, 0, 0, 0);
      m_fails  = 0;
      m_accept = f + N;
    end else begin
      push_exp(EV_FAIL, f, m_fails, 17, 0);
      m_accept = f;
    end
  endtask

  // Levels v are sampled by the DUT on edge s.
  task automatic model_step(input int s, input logic [3:0] v);
    logic [3:0] r;
    int         d;
    int         sec;
    bit         ok;
    r      = v & ~m_prev;
    m_prev = v;
    if (m_code.size() > 0 && s == m_last + T + 1) begin
      m_code.delete();
      model_fail(s + 1);
    end
    if (r != 4'b0000 && s >= m_accept) begin
      d = -1;
      if ($countones(r) == 1 && v == r)
        for (int b = 0; b < 4; b++) if (r[b]) d = b;
      m_code.push_back(d);
      m_last = s;
      if (m_code.size() == 4) begin
        sec = int'(CODE);
        ok  = 1'b1;
        for (int i = 0; i < 4; i++)
          if (m_code[i] != ((sec >> (2 * i)) & 3)) ok = 1'b0;
        m_code.delete();
        if (ok) begin
          push_exp(EV_UNLOCK, s + 2, 0, 12, 0);
          m_fails  = 0;
          m_accept = s + 2;
        end else begin
          model_fail(s + 2);
        end
      end
    end
  endtask

  task automatic step(input logic [3:0] v);
    @(posedge clkin);
    #1;
    lv = v;
    model_step(cyc + 1, v);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'b0000);
  endtask

  task automatic press(input int b, input int gap);
    step(4'(1 << b));
    idle(gap);
  endtask

  task automatic enter4(input int d0, input int d1, input int d2, input int d3, input int gap);
    press(d0, gap);
    press(d1, gap);
    press(d2, gap);
    press(d3, gap);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_unlock"}, int'(unlock), 0);
    check({tag, "_fail"}, int'(fail), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_fail_cnt"}, int'(fail_cnt), 0);
    check({tag, "_out"}, int'(OUT), 0);
  endtask

  // Assert reset in the middle of a cycle and check outputs before any clock edge.
  task automatic async_reset(input string tag);
    @(posedge clkin);
    #3;
    reset = 1'b0;
    #1;
    check_reset_values(tag);
    lv = 4'b0000;
    model_reset();
    repeat (2) @(posedge clkin);
    #3;
    reset = 1'b1;
  endtask

  // Monitor: pops the expected event whenever the DUT presents one.
  bit   mon_prev_locked = 1'b0;
  int   mon_ev;
  exp_t mon_e;

  initial begin
    forever begin
      @(negedge clkin);
      if (reset) begin
        if (unlock || fail) check("pulse_exclusive", int'(unlock && fail), 0);
        mon_ev = -1;
        if (unlock) mon_ev = EV_UNLOCK;
        else if (fail) mon_ev = EV_FAIL;
        else if (mon_prev_locked && !locked) mon_ev = EV_LOCKEND;
        if (mon_ev >= 0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_event", mon_ev, -1);
          end else begin
            mon_e = exp_q.pop_front();
            check("ev_kind", mon_ev, mon_e.kind);
            check("ev_cycle", cyc, mon_e.cyc);
            check("ev_fail_cnt", int'(fail_cnt), mon_e.fcnt);
            check("ev_out", int'(OUT), mon_e.out);
            check("ev_locked", int'(locked), mon_e.lck);
          end
        end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
          check("missed_event_cycle", cyc, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
      end
      mon_prev_locked = locked;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int         r_h;
  logic [3:0] r_v;

  initial begin
    model_reset();
    repeat (3) @(posedge clkin);
    #1;
    check_reset_values("reset");
    #2;
    reset = 1'b1;

    // Correct code with OUT stepping through the digit index.
    press(0, 4);
    check("t1_out_1", int'(OUT), 1);
    press(1, 4);
    check("t1_out_2", int'(OUT), 2);
    press(2, 4);
    check("t1_out_3", int'(OUT), 3);
    press(3, 8);
    check("t1_fail_cnt", int'(fail_cnt), m_fails);

    // Wrong order.
    enter4(0, 1, 3, 2, 2);
    idle(3);
    check("t2_out_idle", int'(OUT), 0);
    check("t2_fail_cnt", int'(fail_cnt), m_fails);

    // Two buttons rising together count as one wrong digit.
    press(0, 2);
    step(4'b0110);
    step(4'b0000);
    idle(1);
    press(2, 2);
    press(3, 6);

    // Holding the last button produces a single press.
    press(0, 2);
    press(1, 2);
    press(2, 2);
    repeat (30) step(4'b1000);
    idle(6);

    // Timeout, then a press landing on the last allowed cycle.
    press(0, T + 10);
    press(0, T - 1);
    press(1, 1);
    press(2, 1);
    press(3, 6);

    // Lockout after three wrong codes; presses inside it are ignored.
    for (int k = 0; k < 3; k++) begin
      enter4(3, 3, 3, 3, 2);
      idle(2);
    end
    idle(10);
    check("t5_locked", int'(locked), 1);
    check("t5_out_lock", int'(OUT), 31);
    enter4(0, 1, 2, 3, 1);
    idle(N + 10);
    check("t5_unlocked", int'(locked), 0);
    enter4(0, 1, 2, 3, 2);
    idle(6);

    // Reset mid-lock, then a fresh correct code.
    for (int k = 0; k < 3; k++) begin
      enter4(1, 1, 1, 1, 2);
      idle(2);
    end
    idle(10);
    async_reset("rst_lock");
    enter4(0, 1, 2, 3, 2);
    idle(6);

    // Reset mid-entry after two digits.
    press(0, 2);
    press(1, 2);
    async_reset("rst_entry");
    enter4(0, 1, 2, 3, 2);
    idle(6);

    // Randomised traffic.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: press(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
        4: begin
          step(4'($urandom_range(1, 15)));
          idle(int'($urandom_range(0, 3)));
        end
        5: idle(int'($urandom_range(5, 25)));
        6: begin
          r_h = int'($urandom_range(2, 8));
          r_v = 4'(1 << $urandom_range(0, 3));
          repeat (r_h) step(r_v);
          step(4'b0000);
        end
        default: enter4(0, 1, 2, 3, int'($urandom_range(1, 3)));
      endcase
    end

    idle(120);
    repeat (2) @(negedge clkin);
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
